// File: rtl/svga_fb_scanout.sv
// svga_fb_scanout: framebuffer scan-out engine between svga_gen and VRAM.
// It turns screen coordinates into 32-bit VRAM word reads and unpacks
// 1/2/4/8 bpp pixels. Each axis has its own power-of-two scaling. Each pixel
// then goes through a 256x12 palette or a direct RGB332 decode.
// Pipeline: S0 address, S1 memory, S2 unpack/palette read, S3 colour register.
// Ports:
//   video_clk, reset          pixel clock, synchronous active-high reset
//   frame, screen_x/y, enable timing from svga_gen (signed coordinates)
//   cfg_*                     framebuffer config, shadowed on frame
//   pal_we/pal_addr/pal_wdata palette write port
//   mem_addr, mem_rdata       VRAM read port (data one cycle after address)
//   paint_r/g/b               4:4:4 colour, gated by enable
module svga_fb_scanout #(
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int ADDR_WIDTH  = 11,
    parameter int COORD_WIDTH = 11
) (
    input  logic                   video_clk,
    input  logic                   reset,
    input  logic                   frame,
    input  logic [COORD_WIDTH-1:0] screen_x,
    input  logic [COORD_WIDTH-1:0] screen_y,
    input  logic                   enable,
    input  logic [ADDR_WIDTH-1:0]  cfg_base,
    input  logic [ADDR_WIDTH-1:0]  cfg_stride,
    input  logic [1:0]             cfg_bpp,
    input  logic                   cfg_direct,
    input  logic [1:0]             cfg_scale_x,
    input  logic [1:0]             cfg_scale_y,
    input  logic                   pal_we,
    input  logic [7:0]             pal_addr,
    input  logic [11:0]            pal_wdata,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [31:0]            mem_rdata,
    output logic [3:0]             paint_r,
    output logic [3:0]             paint_g,
    output logic [3:0]             paint_b
);

    localparam int          LAT  = 4;
    localparam int unsigned CW   = COORD_WIDTH;
    localparam int unsigned AW   = ADDR_WIDTH;
    localparam int unsigned BP_W = COORD_WIDTH + 3;

    localparam logic signed [CW-1:0] X_FIRST = CW'(-LAT);
    localparam logic signed [CW-1:0] X_END   = CW'(H_ACTIVE - LAT);
    localparam logic signed [CW-1:0] X_LAST  = CW'(H_ACTIVE - LAT - 1);
    localparam logic signed [CW-1:0] Y_END   = CW'(V_ACTIVE);

    // Shadow configuration and scan counters
    logic [AW-1:0] sh_stride;
    logic [1:0]    sh_bpp;
    logic          sh_direct;
    logic [1:0]    sh_scale_x;
    logic [1:0]    sh_scale_y;
    logic [AW-1:0] line_base;
    logic [CW-1:0] hcnt;
    // Only the low three bits of the line count matter (scale_y <= 3)
    logic [2:0]    vcnt;
    logic          active;

    // Pipeline registers
    logic          s1_v, s2_v, s3_v;
    logic [4:0]    s1_shift, s2_shift;
    logic [1:0]    s1_bpp, s2_bpp;
    logic          s1_direct, s2_direct, s3_direct;
    logic [11:0]   s3_rgb;
    logic [11:0]   pal_q;
    logic [11:0]   colour;

    logic [11:0]   pal_mem [256];

    // S0 address generation
    logic signed [CW-1:0] sx, sy;
    logic                 fetch_en;
    logic                 line_end;
    logic [BP_W-1:0]      bitpos;
    logic [AW-1:0]        fetch_addr;
    logic [2:0]           ymask;

    assign sx       = $signed(screen_x);
    assign sy       = $signed(screen_y);
    assign fetch_en = active && !sy[CW-1] && (sy < Y_END) &&
                      (sx >= X_FIRST) && (sx < X_END);
    assign line_end = (sx == X_LAST);
    assign bitpos   = BP_W'(hcnt >> sh_scale_x) << sh_bpp;
    assign fetch_addr = line_base + AW'(bitpos[BP_W-1:5]);
    assign ymask    = 3'((8'd1 << sh_scale_y) - 8'd1);

    // S2 unpack: pixel 0 of a word sits in the LSBs
    logic [7:0]  shifted;
    logic [7:0]  pix;
    logic [11:0] direct_rgb;

    assign shifted = 8'(mem_rdata >> s2_shift);

    always_comb begin
        pix = 8'd0;
        case (s2_bpp)
            2'd0:    pix = {7'd0, shifted[0]};
            2'd1:    pix = {6'd0, shifted[1:0]};
            2'd2:    pix = {4'd0, shifted[3:0]};
            default: pix = shifted;
        endcase
    end

    // RGB332 expanded to 4:4:4 by replicating the low bits
    assign direct_rgb = {pix[2:0], pix[0], pix[5:3], pix[3], pix[7:6], pix[6], pix[6]};

    // Palette: synchronous read, a same-cycle write is seen next cycle
    always_ff @(posedge video_clk) begin
        if (pal_we) begin
            pal_mem[pal_addr] <= pal_wdata;
        end
        pal_q <= pal_mem[pix];
    end

    // Shadow config, counters and pipeline
    always_ff @(posedge video_clk) begin
        if (reset) begin
            sh_stride  <= '0;
            sh_bpp     <= '0;
            sh_direct  <= 1'b0;
            sh_scale_x <= '0;
            sh_scale_y <= '0;
            line_base  <= '0;
            hcnt       <= '0;
            vcnt       <= '0;
            active     <= 1'b0;
            mem_addr   <= '0;
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            s3_v       <= 1'b0;
            s1_shift   <= '0;
            s2_shift   <= '0;
            s1_bpp     <= '0;
            s2_bpp     <= '0;
            s1_direct  <= 1'b0;
            s2_direct  <= 1'b0;
            s3_direct  <= 1'b0;
            s3_rgb     <= '0;
            colour     <= '0;
        end else begin
            if (frame) begin
                sh_stride  <= cfg_stride;
                sh_bpp     <= cfg_bpp;
                sh_direct  <= cfg_direct;
                sh_scale_x <= cfg_scale_x;
                sh_scale_y <= cfg_scale_y;
                line_base  <= cfg_base;
                hcnt       <= '0;
                vcnt       <= '0;
                active     <= 1'b1;
            end else if (fetch_en) begin
                mem_addr <= fetch_addr;
                if (line_end) begin
                    hcnt <= '0;
                    vcnt <= vcnt + 3'd1;
                    // Advance only after the last repeat of a scaled line
                    if ((vcnt & ymask) == ymask) begin
                        line_base <= line_base + sh_stride;
                    end
                end else begin
                    hcnt <= hcnt + CW'(1);
                end
            end

            // Per-pixel format travels with the data so a mid-pipeline
            // frame pulse cannot corrupt pixels already in flight
            s1_v      <= fetch_en && !frame;
            s1_shift  <= bitpos[4:0];
            s1_bpp    <= sh_bpp;
            s1_direct <= sh_direct && (sh_bpp == 2'd3);

            s2_v      <= s1_v;
            s2_shift  <= s1_shift;
            s2_bpp    <= s1_bpp;
            s2_direct <= s1_direct;

            s3_v      <= s2_v;
            s3_direct <= s2_direct;
            s3_rgb    <= direct_rgb;

            colour    <= s3_v ? (s3_direct ? s3_rgb : pal_q) : 12'd0;
        end
    end

    assign paint_r = enable ? colour[11:8] : 4'd0;
    assign paint_g = enable ? colour[7:4]  : 4'd0;
    assign paint_b = enable ? colour[3:0]  : 4'd0;

endmodule

// File: tb/tb_svga_fb_scanout.sv
// Directed testbench for svga_fb_scanout with a registered VRAM model.
module tb_svga_fb_scanout;

    localparam int H  = 64;
    localparam int V  = 16;
    localparam int AW = 11;
    localparam int CW = 11;
    localparam int NONE = -1000;

    logic          video_clk = 1'b0;
    logic          reset;
    logic          frame;
    logic [CW-1:0] screen_x;
    logic [CW-1:0] screen_y;
    logic          enable;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_stride;
    logic [1:0]    cfg_bpp;
    logic          cfg_direct;
    logic [1:0]    cfg_scale_x;
    logic [1:0]    cfg_scale_y;
    logic          pal_we;
    logic [7:0]    pal_addr;
    logic [11:0]   pal_wdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic [3:0]    paint_r;
    logic [3:0]    paint_g;
    logic [3:0]    paint_b;

    logic [31:0]   vram [2048];
    logic [11:0]   pix_buf  [H];
    logic [AW-1:0] addr_buf [H];

    int checks = 0;
    int errors = 0;

    svga_fb_scanout #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW), .COORD_WIDTH(CW)
    ) dut (
        .video_clk(video_clk), .reset(reset), .frame(frame),
        .screen_x(screen_x), .screen_y(screen_y), .enable(enable),
        .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_bpp(cfg_bpp),
        .cfg_direct(cfg_direct), .cfg_scale_x(cfg_scale_x), .cfg_scale_y(cfg_scale_y),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .paint_r(paint_r), .paint_g(paint_g), .paint_b(paint_b)
    );

    always #5 video_clk = ~video_clk;

    // VRAM: data valid one cycle after the address
    always @(posedge video_clk) mem_rdata <= vram[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_frame();
        @(negedge video_clk);
        frame    = 1'b1;
        enable   = 1'b0;
        screen_x = CW'(-100);
        screen_y = CW'(-10);
        @(negedge video_clk);
        frame = 1'b0;
    endtask

    task automatic pal_write(input logic [7:0] a, input logic [11:0] d);
        @(negedge video_clk);
        pal_we    = 1'b1;
        pal_addr  = a;
        pal_wdata = d;
        @(negedge video_clk);
        pal_we = 1'b0;
    endtask

    // One scan line; optional palette write to entry 5 and reset pulse at given x
    task automatic scan_line(input int y, input int pw_sx, input logic [11:0] pw_data,
                             input int rst_sx);
        screen_y = CW'(y);
        for (int sx = -8; sx <= H + 1; sx++) begin
            @(negedge video_clk);
            screen_x  = CW'(sx);
            enable    = (sx >= 0) && (sx < H) && (y >= 0) && (y < V);
            pal_we    = (sx == pw_sx);
            pal_addr  = 8'd5;
            pal_wdata = pw_data;
            reset     = (sx == rst_sx);
            #1;
            if (sx >= 0 && sx < H) pix_buf[sx] = {paint_r, paint_g, paint_b};
            // mem_addr now holds the fetch issued at screen_x = sx-1, i.e. pixel sx+3
            if (sx + 3 >= 0 && sx + 3 < H) addr_buf[sx + 3] = mem_addr;
        end
        @(negedge video_clk);
        pal_we = 1'b0;
        reset  = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) vram[i] = 32'd0;
        vram[0]     = 32'h030201FF;
        vram[1]     = 32'hC0380504;
        vram[3]     = 32'hFFFFFFFF;
        vram[4]     = 32'hFFFFFFFF;
        vram[16]    = 32'h00000005;
        vram[17]    = 32'h00000002;
        vram[100]   = 32'h76543210;
        vram[110]   = 32'hFEDCBA98;
        vram[200]   = 32'h05050505;
        vram[12'h7FF] = 32'h000000FF;

        reset = 1'b1; frame = 1'b0; enable = 1'b0;
        screen_x = '0; screen_y = '0;
        cfg_base = '0; cfg_stride = '0; cfg_bpp = '0; cfg_direct = 1'b0;
        cfg_scale_x = '0; cfg_scale_y = '0;
        pal_we = 1'b0; pal_addr = '0; pal_wdata = '0;

        // Reset state
        repeat (3) @(negedge video_clk);
        reset  = 1'b0;
        enable = 1'b1;
        #1;
        check("reset_paint", 32'({paint_r, paint_g, paint_b}), 32'h000);
        check("reset_addr", 32'(mem_addr), 32'h000);

        // Black until first frame pulse
        cfg_bpp = 2'd3; cfg_direct = 1'b1; cfg_scale_x = 2'd3; cfg_scale_y = 2'd3;
        cfg_stride = 11'd2; cfg_base = 11'd0;
        scan_line(0, NONE, 12'h000, NONE);
        check("preframe_x0", 32'(pix_buf[0]), 32'h000);

        // 8bpp direct, scale 8x8
        do_frame();
        scan_line(0, NONE, 12'h000, NONE);
        check("d8_x0",  32'(pix_buf[0]),  32'hFFF);
        check("d8_x7",  32'(pix_buf[7]),  32'hFFF);
        check("d8_x8",  32'(pix_buf[8]),  32'h300);
        check("d8_x16", 32'(pix_buf[16]), 32'h400);
        check("d8_x24", 32'(pix_buf[24]), 32'h700);
        check("d8_x32", 32'(pix_buf[32]), 32'h800);
        check("d8_x40", 32'(pix_buf[40]), 32'hB00);
        check("d8_x48", 32'(pix_buf[48]), 32'h0F0);
        check("d8_x56", 32'(pix_buf[56]), 32'h00F);
        check("d8_a0",  32'(addr_buf[0]),  32'd0);
        check("d8_a31", 32'(addr_buf[31]), 32'd0);
        check("d8_a32", 32'(addr_buf[32]), 32'd1);

        // 1bpp palette, no scaling
        pal_write(8'd0, 12'h000);
        pal_write(8'd1, 12'hF0F);
        cfg_bpp = 2'd0; cfg_direct = 1'b0; cfg_scale_x = 2'd0; cfg_scale_y = 2'd0;
        cfg_base = 11'd16; cfg_stride = 11'd2;
        do_frame();
        scan_line(0, NONE, 12'h000, NONE);
        check("b1_x0",  32'(pix_buf[0]),  32'hF0F);
        check("b1_x1",  32'(pix_buf[1]),  32'h000);
        check("b1_x2",  32'(pix_buf[2]),  32'hF0F);
        check("b1_x3",  32'(pix_buf[3]),  32'h000);
        check("b1_x32", 32'(pix_buf[32]), 32'h000);
        check("b1_x33", 32'(pix_buf[33]), 32'hF0F);
        check("b1_a31", 32'(addr_buf[31]), 32'd16);
        check("b1_a32", 32'(addr_buf[32]), 32'd17);

        // 4bpp, scale_y=2, stride 10; cfg_bpp changed mid-frame
        for (int i = 0; i < 16; i++) pal_write(8'(i), 12'(i * 12'h111));
        cfg_bpp = 2'd2; cfg_base = 11'd100; cfg_stride = 11'd10;
        cfg_scale_x = 2'd0; cfg_scale_y = 2'd1;
        do_frame();
        scan_line(0, NONE, 12'h000, NONE);
        check("b4_l0_x0",  32'(pix_buf[0]),   32'h000);
        check("b4_l0_x3",  32'(pix_buf[3]),   32'h333);
        check("b4_l0_x7",  32'(pix_buf[7]),   32'h777);
        check("b4_l0_a0",  32'(addr_buf[0]),  32'd100);
        check("b4_l0_a63", 32'(addr_buf[63]), 32'd107);
        scan_line(1, NONE, 12'h000, NONE);
        check("b4_l1_a0",  32'(addr_buf[0]),  32'd100);
        check("b4_l1_x5",  32'(pix_buf[5]),   32'h555);
        cfg_bpp = 2'd0;
        scan_line(2, NONE, 12'h000, NONE);
        check("b4_l2_a0",  32'(addr_buf[0]),  32'd110);
        check("b4_l2_a8",  32'(addr_buf[8]),  32'd111);
        check("b4_l2_x0",  32'(pix_buf[0]),   32'h888);
        check("b4_l2_x1",  32'(pix_buf[1]),   32'h999);
        scan_line(3, NONE, 12'h000, NONE);
        check("b4_l3_a0",  32'(addr_buf[0]),  32'd110);
        scan_line(4, NONE, 12'h000, NONE);
        check("b4_l4_a0",  32'(addr_buf[0]),  32'd120);

        // Palette write to entry 5 in the same cycle pixel 0 reads it
        cfg_bpp = 2'd3; cfg_direct = 1'b0; cfg_base = 11'd200; cfg_stride = 11'd16;
        cfg_scale_y = 2'd0;
        do_frame();
        scan_line(0, -2, 12'hA5A, NONE);
        check("pw_x0", 32'(pix_buf[0]), 32'h555);
        check("pw_x1", 32'(pix_buf[1]), 32'hA5A);
        check("pw_x2", 32'(pix_buf[2]), 32'hA5A);

        // Address wrap from 0x7FF to 0x000
        cfg_direct = 1'b1; cfg_base = 11'h7FE; cfg_stride = 11'd4;
        do_frame();
        scan_line(0, NONE, 12'h000, NONE);
        check("wr_a0",  32'(addr_buf[0]),  32'h7FE);
        check("wr_a4",  32'(addr_buf[4]),  32'h7FF);
        check("wr_a8",  32'(addr_buf[8]),  32'h000);
        check("wr_a12", 32'(addr_buf[12]), 32'h001);
        check("wr_x4",  32'(pix_buf[4]),   32'hFFF);
        check("wr_x9",  32'(pix_buf[9]),   32'h300);
        check("wr_x24", 32'(pix_buf[24]),  32'hFFF);
        scan_line(1, NONE, 12'h000, NONE);
        check("wr_l1_a0", 32'(addr_buf[0]), 32'h002);

        // Reset mid-line: black until the next frame, then restart at base
        do_frame();
        scan_line(0, NONE, 12'h000, 20);
        check("rs_x22", 32'(pix_buf[22]), 32'h000);
        check("rs_x24", 32'(pix_buf[24]), 32'h000);
        check("rs_a24", 32'(addr_buf[24]), 32'h000);
        scan_line(1, NONE, 12'h000, NONE);
        check("rs_l1_x4",  32'(pix_buf[4]),  32'h000);
        check("rs_l1_x24", 32'(pix_buf[24]), 32'h000);
        do_frame();
        scan_line(0, NONE, 12'h000, NONE);
        check("rs_new_a0",  32'(addr_buf[0]), 32'h7FE);
        check("rs_new_x4",  32'(pix_buf[4]),  32'hFFF);
        check("rs_new_x24", 32'(pix_buf[24]), 32'hFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
